// File: rtl/kbd_led_ctrl.sv
// PS/2 host-side Set-LEDs sequencer: sends 0xED, waits for ACK, sends the LED
// mask, waits for ACK, with resend/timeout retries and a one-deep request queue.
module kbd_led_ctrl #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       led_req,
  input  logic [2:0] led_val,
  input  logic       din_new,
  input  logic [7:0] din,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] leds_applied
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, SEND_CMD, WAIT_CMD_TX, WAIT_CMD_ACK, RETRY_CMD,
    SEND_ARG, WAIT_ARG_TX, WAIT_ARG_ACK, RETRY_ARG, DONE, FAIL
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;
  logic          pending;
  logic [2:0]    cur_val, pend_val;
  logic          timeout, ack, nak, retry_max;

  assign timeout   = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign ack       = din_new && (din == 8'hFA);
  assign nak       = din_new && (din == 8'hFE);
  assign retry_max = (retry == RW'(MAX_RETRY));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nx;
  end

  // Qualifying events are tested before the timeout so they win a tie.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:         if (pending || led_req) state_nx = SEND_CMD;
      SEND_CMD:     state_nx = WAIT_CMD_TX;
      WAIT_CMD_TX:  if (tx_done) state_nx = WAIT_CMD_ACK;
                    else if (timeout) state_nx = RETRY_CMD;
      WAIT_CMD_ACK: if (ack) state_nx = SEND_ARG;
                    else if (nak || timeout) state_nx = RETRY_CMD;
      RETRY_CMD:    state_nx = retry_max ? FAIL : SEND_CMD;
      SEND_ARG:     state_nx = WAIT_ARG_TX;
      WAIT_ARG_TX:  if (tx_done) state_nx = WAIT_ARG_ACK;
                    else if (timeout) state_nx = RETRY_ARG;
      WAIT_ARG_ACK: if (ack) state_nx = DONE;
                    else if (nak || timeout) state_nx = RETRY_ARG;
      RETRY_ARG:    state_nx = retry_max ? FAIL : SEND_ARG;
      DONE:         state_nx = IDLE;
      FAIL:         state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx_start = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    busy     = (state != IDLE);
    case (state)
      SEND_CMD, SEND_ARG: tx_start = 1'b1;
      DONE:               done     = 1'b1;
      FAIL:               error    = 1'b1;
      default:            ;
    endcase
  end

  // tx_data is loaded on entry to a SEND state so it is valid alongside tx_start.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      timer        <= '0;
      retry        <= '0;
      pending      <= 1'b0;
      tx_data      <= 8'h00;
      leds_applied <= 3'b000;
    end else begin
      case (state)
        SEND_CMD, SEND_ARG:         timer <= '0;
        WAIT_CMD_TX, WAIT_ARG_TX:   timer <= tx_done ? '0 : timer + TW'(1);
        WAIT_CMD_ACK, WAIT_ARG_ACK: timer <= timer + TW'(1);
        default:                    ;
      endcase

      if (state == IDLE)
        retry <= '0;
      else if ((state == RETRY_CMD || state == RETRY_ARG) && !retry_max)
        retry <= retry + RW'(1);

      if (state == IDLE)  pending <= 1'b0;
      else if (led_req)   pending <= 1'b1;

      if (state_nx == SEND_CMD)      tx_data <= 8'hED;
      else if (state_nx == SEND_ARG) tx_data <= {5'b00000, cur_val};

      if (state == DONE) leds_applied <= cur_val;
    end
  end

  // A fresh request in IDLE takes priority over the queued value.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (led_req)      cur_val <= led_val;
      else if (pending) cur_val <= pend_val;
    end
    if (led_req && state != IDLE) pend_val <= led_val;
  end

endmodule

// File: tb/tb_kbd_led_ctrl.sv
// Scoreboard bench for kbd_led_ctrl with a 5-cycle transmitter model and a
// scripted keyboard that replies 3 cycles after each transmitted byte.
module tb_kbd_led_ctrl;
  localparam int TO = 16;
  localparam int MR = 2;

  logic       clk = 1'b0, resetN = 1'b0;
  logic       led_req = 1'b0, din_new = 1'b0, tx_done = 1'b0;
  logic [2:0] led_val = 3'b000;
  logic [7:0] din = 8'h00;
  logic       tx_start, busy, done, error;
  logic [7:0] tx_data;
  logic [2:0] leds_applied;

  kbd_led_ctrl #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .resetN(resetN), .led_req(led_req), .led_val(led_val),
    .din_new(din_new), .din(din), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .done(done), .error(error),
    .leds_applied(leds_applied)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, last_done_cyc = 0, tx_count = 0, gap_tx = -1, inj_seq = 0;
  logic [9:0] exp_q[$];   // {kind, byte}: 1=tx byte, 2=done, 3=error
  int         rep_q[$];   // keyboard reply per transmitted byte, 0 = silent
  logic [7:0] tx_byte = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb(input string name, input logic [9:0] ev);
    logic [9:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event 0x%0h, expected none", name, ev);
    end else begin
      e = exp_q.pop_front();
      if (e !== ev) begin
        errors++;
        $display("FAIL %s: got event 0x%0h, expected 0x%0h", name, ev, e);
      end
    end
  endtask

  // Monitor: samples on the falling edge.
  initial forever begin
    @(negedge clk);
    if (resetN) begin
      if (tx_start) begin
        tx_count++;
        tx_byte = tx_data;
        sb("tx_byte", {2'd1, tx_data});
        if (tx_count == gap_tx) chk("timeout_gap", cyc - last_done_cyc, TO + 2);
      end
      if (done)  sb("done_pulse", 10'h200);
      if (error) sb("error_pulse", 10'h300);
      if (tx_done) begin
        last_done_cyc = cyc;
        chk("tx_data_hold", tx_data, tx_byte);
      end
    end
  end

  // Transmitter model: tx_done 5 cycles after tx_start.
  initial forever begin
    @(negedge clk);
    if (resetN && tx_start) begin
      repeat (5) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
    end
  end

  // Keyboard model: scripted reply 3 cycles after tx_done, or an injected 0xFA.
  initial begin
    int cnt, r, last_inj;
    logic [7:0] byte_q;
    cnt = 0; last_inj = 0; byte_q = 8'h00;
    forever begin
      @(negedge clk);
      if (resetN && tx_done) begin
        r = (rep_q.size() > 0) ? rep_q.pop_front() : 0;
        if (r != 0) begin byte_q = 8'(r); cnt = 3; end
      end
      if (inj_seq != last_inj) begin last_inj = inj_seq; byte_q = 8'hFA; cnt = 1; end
      @(posedge clk);
      #1 din_new = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin din = byte_q; din_new = 1'b1; end
      end
    end
  end

  task automatic req(input logic [2:0] v);
    @(posedge clk); #1 led_req = 1'b1; led_val = v;
    @(posedge clk); #1 led_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    for (int i = 0; i < 600 && quiet < 3; i++) begin
      @(negedge clk);
      quiet = busy ? 0 : quiet + 1;
    end
    chk(name, quiet >= 3, 1);
  endtask

  task automatic wait_tx(input int target);
    for (int i = 0; i < 200 && tx_count < target; i++) @(posedge clk);
    chk("wait_tx_count", tx_count >= target, 1);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {tx_start, tx_data, busy, done, error, leds_applied}, 0);
    @(posedge clk); #1 resetN = 1'b1;
    repeat (2) @(posedge clk);

    // Normal update 3'b101
    rep_q = '{32'hFA, 32'hFA};
    exp_q.push_back(10'h1ED); exp_q.push_back(10'h105); exp_q.push_back(10'h200);
    req(3'b101);
    @(negedge clk);
    chk("start_timing_busy_txstart", {busy, tx_start}, 2'b11);
    wait_idle("normal_idle");
    chk("normal_leds", leds_applied, 3'b101);
    chk("normal_drained", exp_q.size(), 0);

    // Resend on the argument byte
    rep_q = '{32'hFA, 32'hFE, 32'hFA};
    exp_q.push_back(10'h1ED); exp_q.push_back(10'h105);
    exp_q.push_back(10'h105); exp_q.push_back(10'h200);
    req(3'b101);
    wait_idle("resend_idle");
    chk("resend_leds", leds_applied, 3'b101);
    chk("resend_drained", exp_q.size(), 0);

    // Timeout on the command ACK: 16 wait cycles, RETRY, then SEND_CMD
    rep_q = '{0, 32'hFA, 32'hFA};
    exp_q.push_back(10'h1ED); exp_q.push_back(10'h1ED);
    exp_q.push_back(10'h103); exp_q.push_back(10'h200);
    gap_tx = tx_count + 2;
    req(3'b011);
    wait_idle("timeout_idle");
    chk("timeout_leds", leds_applied, 3'b011);
    chk("timeout_drained", exp_q.size(), 0);

    // Retry exhaustion: three 0xED attempts, then error
    rep_q = '{32'hFE, 32'hFE, 32'hFE};
    exp_q.push_back(10'h1ED); exp_q.push_back(10'h1ED);
    exp_q.push_back(10'h1ED); exp_q.push_back(10'h300);
    req(3'b110);
    wait_idle("exhaust_idle");
    chk("exhaust_leds_kept", leds_applied, 3'b011);
    chk("exhaust_busy", busy, 0);
    chk("exhaust_drained", exp_q.size(), 0);

    // Queued requests: only the latest (3'b010) follows
    rep_q = '{32'hFA, 32'hFA, 32'hFA, 32'hFA};
    exp_q.push_back(10'h1ED); exp_q.push_back(10'h104); exp_q.push_back(10'h200);
    exp_q.push_back(10'h1ED); exp_q.push_back(10'h102); exp_q.push_back(10'h200);
    req(3'b100);
    repeat (3) @(posedge clk);
    req(3'b001);
    repeat (2) @(posedge clk);
    req(3'b010);
    wait_idle("queue_idle");
    chk("queue_leds", leds_applied, 3'b010);
    chk("queue_drained", exp_q.size(), 0);

    // Reset while in WAIT_ARG_ACK
    rep_q = '{32'hFA, 0};
    exp_q.push_back(10'h1ED); exp_q.push_back(10'h107);
    base = tx_count;
    req(3'b111);
    wait_tx(base + 2);
    repeat (7) @(posedge clk);
    #1 resetN = 1'b0;
    #1 chk("midreset_outputs", {tx_start, tx_data, busy, done, error, leds_applied}, 0);
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    repeat (2) @(posedge clk);
    inj_seq++;
    repeat (6) @(negedge clk);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_leds", leds_applied, 3'b000);
    chk("reset_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
